// File: rtl/gray_port_arbiter_if.sv
// Bundle for the shared gray-image read port and the two requester ports.
// The arbiter connects through the master modport.
// The environment (memory model and requesters) connects through the slave modport.
interface gray_port_arbiter_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 8
);
  // Image memory read port
  logic [ADDR_W-1:0] gray_addr;
  logic              gray_req;
  logic [DATA_W-1:0] gray_data;

  // Requester 0: LBP line-buffer loader
  logic              r0_req;
  logic [ADDR_W-1:0] r0_addr;
  logic              r0_gnt;
  logic              r0_rvalid;
  logic [DATA_W-1:0] r0_rdata;

  // Requester 1: secondary engine (histogram / statistics)
  logic              r1_req;
  logic [ADDR_W-1:0] r1_addr;
  logic              r1_gnt;
  logic              r1_rvalid;
  logic [DATA_W-1:0] r1_rdata;

  modport master (
    output gray_addr, gray_req,
    input  gray_data,
    input  r0_req, r0_addr,
    output r0_gnt, r0_rvalid, r0_rdata,
    input  r1_req, r1_addr,
    output r1_gnt, r1_rvalid, r1_rdata
  );

  modport slave (
    input  gray_addr, gray_req,
    output gray_data,
    output r0_req, r0_addr,
    input  r0_gnt, r0_rvalid, r0_rdata,
    output r1_req, r1_addr,
    input  r1_gnt, r1_rvalid, r1_rdata
  );
endinterface

// File: rtl/gray_port_arbiter.sv
// gray_port_arbiter: shares one gray-image read port between two pixel-fetch engines.
// The default policy is sticky round-robin with a burst cap.
// A tag pipeline follows every issued read so that the returned byte reaches the requester that asked for it.
// Frames start on gray_ready and end on frame_done, followed by a drain of outstanding reads.
// Optional macro GRAY_ARB_FIXED_PRIO_EN selects the fixed-priority policy.
// In that policy requester 0 always wins contention.
module gray_port_arbiter #(
  parameter int ADDR_W    = 14,
  parameter int DATA_W    = 8,
  parameter int BURST_MAX = 16,
  parameter int MEM_LAT   = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic gray_ready,
  input  logic frame_done,
  output logic busy,
  output logic done,
  gray_port_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    WAIT_READY = 2'd0,
    RUN        = 2'd1,
    DRAIN      = 2'd2
  } state_t;

  localparam logic [7:0] BURST_CAP = 8'(BURST_MAX);

  state_t            state_q, state_d;
  logic              owner_q, owner_d;         // 0: requester 0 holds priority
  logic [7:0]        burst_cnt_q, burst_cnt_d;
  logic              busy_q, done_q, done_d;

  // Issue stage: aligned with gray_req on the memory port
  logic              gray_req_q;
  logic [ADDR_W-1:0] gray_addr_q;
  logic              issue_id_q;

  // Return tags: the last stage lines up with gray_data
  logic              tag_vld_q [MEM_LAT];
  logic              tag_id_q  [MEM_LAT];

  logic              gnt0, gnt1, gnt_any;
  logic [ADDR_W-1:0] gnt_addr;
  logic              drain_empty;
  logic [DATA_W-1:0] rdata_w;

  // Grant decision for this cycle; grants only in RUN with memory ready and no frame end
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset && state_q == RUN && gray_ready && !frame_done) begin
`ifdef GRAY_ARB_FIXED_PRIO_EN
      if (bus.r0_req) begin
        gnt0 = 1'b1;
      end else if (bus.r1_req) begin
        gnt1 = 1'b1;
      end
`else
      if (bus.r0_req && bus.r1_req) begin
        if (burst_cnt_q >= BURST_CAP) begin
          // Owner has used up its burst: hand this slot to the other side
          gnt0 = owner_q;
          gnt1 = !owner_q;
        end else begin
          gnt0 = !owner_q;
          gnt1 = owner_q;
        end
      end else if (bus.r0_req) begin
        gnt0 = 1'b1;
      end else if (bus.r1_req) begin
        gnt1 = 1'b1;
      end
`endif
    end
  end

  assign gnt_any  = gnt0 | gnt1;
  assign gnt_addr = gnt1 ? bus.r1_addr : bus.r0_addr;

  // Owner and burst bookkeeping; the counter saturates at the cap so that a long solo run still yields on contention
  always_comb begin
    owner_d     = owner_q;
    burst_cnt_d = burst_cnt_q;
    if (gnt_any) begin
      if (gnt1 == owner_q) begin
        if (burst_cnt_q < BURST_CAP) begin
          burst_cnt_d = burst_cnt_q + 8'd1;
        end
      end else begin
        owner_d     = gnt1;
        burst_cnt_d = 8'd1;
      end
    end
  end

  // A read still in flight anywhere except the stage being delivered now keeps DRAIN waiting
  always_comb begin
    drain_empty = !gray_req_q;
    for (int i = 0; i < MEM_LAT - 1; i++) begin
      if (tag_vld_q[i]) begin
        drain_empty = 1'b0;
      end
    end
  end

  // Frame sequencing: next state and the done pulse on leaving DRAIN
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      WAIT_READY: begin
        if (gray_ready) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (frame_done) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (drain_empty) begin
          state_d = WAIT_READY;
          done_d  = 1'b1;
        end
      end
      default: state_d = WAIT_READY;
    endcase
  end

  // Control state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= WAIT_READY;
      owner_q     <= 1'b0;
      burst_cnt_q <= 8'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
      busy_q      <= (state_d != WAIT_READY);
      done_q      <= done_d;
    end
  end

  // Issue register: a grant in one cycle drives the memory port in the next cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      gray_req_q  <= 1'b0;
      gray_addr_q <= '0;
      issue_id_q  <= 1'b0;
    end else begin
      gray_req_q <= gnt_any;
      if (gnt_any) begin
        gray_addr_q <= gnt_addr;
        issue_id_q  <= gnt1;
      end
    end
  end

  // Tag pipeline: one stage per cycle of memory latency
  for (genvar gi = 0; gi < MEM_LAT; gi++) begin : g_tag
    if (gi == 0) begin : g_first
      // First stage captures the read that is on the memory port now
      always_ff @(posedge clk) begin
        if (reset) begin
          tag_vld_q[gi] <= 1'b0;
          tag_id_q[gi]  <= 1'b0;
        end else begin
          tag_vld_q[gi] <= gray_req_q;
          tag_id_q[gi]  <= issue_id_q;
        end
      end
    end else begin : g_rest
      // Later stages shift the tag along until its data returns
      always_ff @(posedge clk) begin
        if (reset) begin
          tag_vld_q[gi] <= 1'b0;
          tag_id_q[gi]  <= 1'b0;
        end else begin
          tag_vld_q[gi] <= tag_vld_q[gi-1];
          tag_id_q[gi]  <= tag_id_q[gi-1];
        end
      end
    end
  end

  assign rdata_w = bus.gray_data;

  assign bus.gray_req  = gray_req_q;
  assign bus.gray_addr = gray_addr_q;
  assign bus.r0_gnt    = gnt0;
  assign bus.r1_gnt    = gnt1;
  assign bus.r0_rvalid = !reset && tag_vld_q[MEM_LAT-1] && !tag_id_q[MEM_LAT-1];
  assign bus.r1_rvalid = !reset && tag_vld_q[MEM_LAT-1] &&  tag_id_q[MEM_LAT-1];
  assign bus.r0_rdata  = rdata_w;
  assign bus.r1_rdata  = rdata_w;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_gray_port_arbiter.sv
// Directed bench for gray_port_arbiter, with BURST_MAX=4 and MEM_LAT=3.
// A negedge monitor tracks issue alignment and return routing.
// Each test phase adds hand-computed checks.
module tb_gray_port_arbiter;
  localparam int AW      = 14;
  localparam int DW      = 8;
  localparam int TB_BURST = 4;
  localparam int TB_LAT  = 3;

  logic clk = 1'b0;
  logic reset, gray_ready, frame_done;
  logic busy, done;

  gray_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) intf ();

  gray_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .BURST_MAX(TB_BURST), .MEM_LAT(TB_LAT)
  ) dut (
    .clk(clk), .reset(reset), .gray_ready(gray_ready), .frame_done(frame_done),
    .busy(busy), .done(done), .bus(intf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [7:0] mem_val(input logic [AW-1:0] a);
    logic [31:0] v;
    v = 32'(a) * 32'd29 + 32'(a >> 7) + 32'd90;
    return v[7:0];
  endfunction

  // Memory model: data appears TB_LAT cycles after gray_req is sampled
  logic [7:0] mpipe [TB_LAT];
  always @(posedge clk) begin
    mpipe[0] <= intf.gray_req ? mem_val(intf.gray_addr) : 8'h00;
    for (int i = 1; i < TB_LAT; i++) mpipe[i] <= mpipe[i-1];
  end
  assign intf.gray_data = mpipe[TB_LAT-1];

  // Scoreboard of outstanding reads per requester
  typedef struct { logic [AW-1:0] addr; int due; } exp_t;
  exp_t exp0[$];
  exp_t exp1[$];
  exp_t e_m;
  logic prev_gnt = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  int rv0_cnt = 0, rv1_cnt = 0, done_cnt = 0, done_cyc = -1, last_rv_cyc = -1;

  always @(negedge clk) begin
    if (reset) begin
      exp0.delete();
      exp1.delete();
      prev_gnt = 1'b0;
    end else begin
      check_eq("iss_req", intf.gray_req, prev_gnt);
      if (prev_gnt) check_eq("iss_addr", intf.gray_addr, prev_addr);
      check_eq("one_gnt", intf.r0_gnt & intf.r1_gnt, 0);
      if (intf.r0_rvalid) begin
        rv0_cnt++; last_rv_cyc = cyc;
        if (exp0.size() == 0) check_eq("rv0_unexp", 1, 0);
        else begin
          e_m = exp0.pop_front();
          check_eq("rv0_cyc", cyc, e_m.due);
          check_eq("rv0_data", intf.r0_rdata, mem_val(e_m.addr));
        end
      end else if (exp0.size() > 0 && exp0[0].due == cyc) check_eq("rv0_miss", 0, 1);
      if (intf.r1_rvalid) begin
        rv1_cnt++; last_rv_cyc = cyc;
        if (exp1.size() == 0) check_eq("rv1_unexp", 1, 0);
        else begin
          e_m = exp1.pop_front();
          check_eq("rv1_cyc", cyc, e_m.due);
          check_eq("rv1_data", intf.r1_rdata, mem_val(e_m.addr));
        end
      end else if (exp1.size() > 0 && exp1[0].due == cyc) check_eq("rv1_miss", 0, 1);
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (intf.r0_gnt) exp0.push_back('{addr: intf.r0_addr, due: cyc + 1 + TB_LAT});
      if (intf.r1_gnt) exp1.push_back('{addr: intf.r1_addr, due: cyc + 1 + TB_LAT});
      prev_gnt  = intf.r0_gnt | intf.r1_gnt;
      prev_addr = intf.r0_gnt ? intf.r0_addr : intf.r1_addr;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic do_reset(input logic ready);
    reset = 1'b1; frame_done = 1'b0; gray_ready = ready;
    intf.r0_req = 1'b0; intf.r1_req = 1'b0;
    step();
    reset = 1'b0;
    sample();
    check_eq("rst_gray_req", intf.gray_req, 0);
    check_eq("rst_gray_addr", intf.gray_addr, 0);
    check_eq("rst_gnt", {intf.r0_gnt, intf.r1_gnt}, 0);
    check_eq("rst_rvalid", {intf.r0_rvalid, intf.r1_rvalid}, 0);
    check_eq("rst_busy_done", {busy, done}, 0);
    step();
  endtask

  task automatic wait_run(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      sample(); seen = busy; step();
    end
    check_eq(tag, seen, 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin sample(); step(); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] pat;
    logic [AW-1:0] a0, a1;
    int base0, base1, fd_cyc;
    logic got_done;

    intf.r0_addr = '0; intf.r1_addr = '0;
    do_reset(1'b0);

    // WAIT_READY: no grants without gray_ready, frame_done ignored
    intf.r0_req = 1'b1; intf.r0_addr = 14'd7; frame_done = 1'b1;
    sample(); check_eq("t0_gnt", intf.r0_gnt, 0); check_eq("t0_busy", busy, 0); step();
    frame_done = 1'b0;
    for (int k = 0; k < 2; k++) begin
      sample(); check_eq("t0_gnt_hold", intf.r0_gnt, 0); check_eq("t0_busy_hold", busy, 0); step();
    end
    gray_ready = 1'b1;
    sample(); check_eq("t0_gnt_wait", intf.r0_gnt, 0); step();
    sample(); check_eq("t0_busy_run", busy, 1); check_eq("t0_gnt_run", intf.r0_gnt, 1); step();
    intf.r0_req = 1'b0;
    $display("phase 0: wait_ready and start of frame");

    // Test 1: r0 alone, addresses 0..257 back to back
    do_reset(1'b1);
    wait_run("t1_run");
    base0 = rv0_cnt;
    for (int a = 0; a < 258; a++) begin
      intf.r0_req = 1'b1; intf.r0_addr = 14'(a);
      sample();
      check_eq("t1_gnt0", intf.r0_gnt, 1);
      if (a > 0) begin
        check_eq("t1_req", intf.gray_req, 1);
        check_eq("t1_addr", intf.gray_addr, 32'(a - 1));
      end
      step();
    end
    intf.r0_req = 1'b0;
    idle(TB_LAT + 3);
    check_eq("t1_rv_cnt", rv0_cnt - base0, 258);
    $display("phase 1: 258 back-to-back r0 reads");

    // Test 2: both requesting continuously, burst cap 4
    do_reset(1'b1);
    wait_run("t2_run");
`ifdef GRAY_ARB_FIXED_PRIO_EN
    pat = 12'b0000_0000_0000;
`else
    pat = 12'b0000_1111_0000;
`endif
    a0 = 14'd100; a1 = 14'd200;
    for (int k = 0; k < 12; k++) begin
      intf.r0_req = 1'b1; intf.r1_req = 1'b1;
      intf.r0_addr = a0; intf.r1_addr = a1;
      sample();
      check_eq("t2_gnt0", intf.r0_gnt, !pat[k]);
      check_eq("t2_gnt1", intf.r1_gnt, pat[k]);
      if (k > 0) check_eq("t2_req", intf.gray_req, 1);
      if (intf.r0_gnt) a0 = a0 + 1'b1;
      if (intf.r1_gnt) a1 = a1 + 1'b1;
      step();
    end
    intf.r0_req = 1'b0; intf.r1_req = 1'b0;
    idle(TB_LAT + 3);
    $display("phase 2: contention grant pattern");

    // Test 3: alternating single grants r0, r1, r0
    base0 = rv0_cnt; base1 = rv1_cnt;
    intf.r0_req = 1'b1; intf.r0_addr = 14'd300;
    sample(); check_eq("t3_g0a", intf.r0_gnt, 1); step();
    intf.r0_req = 1'b0; intf.r1_req = 1'b1; intf.r1_addr = 14'd301;
    sample(); check_eq("t3_g1", intf.r1_gnt, 1); step();
    intf.r1_req = 1'b0; intf.r0_req = 1'b1; intf.r0_addr = 14'd302;
    sample(); check_eq("t3_g0b", intf.r0_gnt, 1); step();
    intf.r0_req = 1'b0;
    idle(TB_LAT + 3);
    check_eq("t3_rv0_cnt", rv0_cnt - base0, 2);
    check_eq("t3_rv1_cnt", rv1_cnt - base1, 1);
    $display("phase 3: alternating routing");

    // Test 4: frame_done with two reads in flight
    base0 = rv0_cnt;
    intf.r0_req = 1'b1; intf.r0_addr = 14'd400;
    sample(); check_eq("t4_g0", intf.r0_gnt, 1); step();
    intf.r0_addr = 14'd401;
    sample(); check_eq("t4_g1", intf.r0_gnt, 1); step();
    intf.r0_addr = 14'd402; frame_done = 1'b1;
    sample(); fd_cyc = cyc; check_eq("t4_fd_gnt", intf.r0_gnt, 0); step();
    frame_done = 1'b0;
    got_done = 1'b0;
    for (int i = 0; i < 20 && !got_done; i++) begin
      sample();
      check_eq("t4_drain_gnt", intf.r0_gnt, 0);
      if (done) begin
        got_done = 1'b1;
        check_eq("t4_busy_at_done", busy, 0);
      end
      step();
    end
    intf.r0_req = 1'b0;
    check_eq("t4_done_seen", got_done, 1);
    sample(); check_eq("t4_done_pulse", done, 0); step();
    check_eq("t4_done_cyc", done_cyc, fd_cyc + TB_LAT + 1);
    check_eq("t4_done_after_rv", done_cyc, last_rv_cyc + 1);
    check_eq("t4_rv_cnt", rv0_cnt - base0, 2);
    $display("phase 4: frame end drain");

    // Test 5: gray_ready dropped for 5 cycles with r0 requesting
    wait_run("t5_run");
    intf.r0_req = 1'b1; intf.r0_addr = 14'd500;
    sample(); check_eq("t5_g0", intf.r0_gnt, 1); step();
    intf.r0_addr = 14'd501; gray_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      sample();
      check_eq("t5_hold_gnt", intf.r0_gnt, 0);
      if (k > 0) check_eq("t5_hold_req", intf.gray_req, 0);
      check_eq("t5_busy", busy, 1);
      step();
    end
    gray_ready = 1'b1;
    sample(); check_eq("t5_resume_gnt", intf.r0_gnt, 1); step();
    intf.r0_req = 1'b0;
    sample(); check_eq("t5_resume_req", intf.gray_req, 1); check_eq("t5_resume_addr", intf.gray_addr, 501); step();
    idle(TB_LAT + 2);
    $display("phase 5: gray_ready hold");

    // Test 6: reset with one read in flight
    intf.r0_req = 1'b1; intf.r0_addr = 14'd600;
    sample(); check_eq("t6_g0", intf.r0_gnt, 1); step();
    base0 = rv0_cnt;
    do_reset(1'b1);
    for (int k = 0; k < TB_LAT + 3; k++) begin
      sample(); check_eq("t6_no_rv", intf.r0_rvalid, 0); step();
    end
    check_eq("t6_rv_cnt", rv0_cnt - base0, 0);
    $display("phase 6: reset discards in-flight read");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
